mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit bridging a 16-bit pipeline to a byte-wide memory.
// Word accesses are split big-endian into two byte transfers.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  memRead,
    input  logic [1:0]  memWrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic        word_q, word_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        req;
    logic        word_req;
    logic        bad;

    always_comb begin
        req      = (memRead != 2'd0) || (memWrite != 2'd0);
        word_req = (memRead == 2'd1) || (memWrite == 2'd1);
        bad      = (memRead == 2'd3) || (memWrite == 2'd3)
                || ((memRead != 2'd0) && (memWrite != 2'd0))
                || (word_req && addr[0]);
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        mem_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        wr_d    = (memWrite != 2'd0);
                        word_d  = word_req;
                        addr_d  = addr;
                        wdata_d = wdata;
                        rdata_d = 16'h0000;
                        state_d = BYTE0;
                    end
                end
            end
            BYTE0: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (!wr_q) begin
                        if (word_q) rdata_d[15:8] = mem_rdata;
                        else        rdata_d = {8'h00, mem_rdata};
                    end
                    state_d = word_q ? BYTE1 : DONE;
                end
            end
            BYTE1: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (!wr_q) rdata_d[7:0] = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            word_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // High byte travels first for word accesses.
    always_comb begin
        done      = (state_q == DONE);
        err       = err_q;
        rdata     = rdata_q;
        mem_we    = mem_req & wr_q;
        mem_addr  = (state_q == BYTE1) ? (addr_q + 16'd1) : addr_q;
        mem_wdata = ((state_q == BYTE0) && word_q) ? wdata_q[15:8]
                                                   : wdata_q[7:0];
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte memory model
// whose acknowledge can be delayed by a programmable number of cycles.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  memRead, memWrite;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        stall, done, err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    int          total = 0;
    int          bad = 0;
    int          dly = 0;
    int          cnt = 0;
    logic        force_ack = 1'b0;
    logic [7:0]  mem [0:255];
    logic        wr_flag [0:255];

    mem_access_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hAB;
            8'h11:   return 8'hCD;
            8'h20:   return 8'h77;
            8'h21:   return 8'hF0;
            8'h22:   return 8'h99;
            default: return 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] peek(input logic [7:0] a);
        return wr_flag[a] ? mem[a] : init_byte(a);
    endfunction

    assign mem_rdata = peek(mem_addr[7:0]);
    assign mem_ack   = force_ack | (mem_req && (cnt >= dly));

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) wr_flag[i] <= 1'b0;
            cnt <= 0;
        end else if (mem_req) begin
            if (mem_ack) begin
                cnt <= 0;
                if (mem_we) begin
                    mem[mem_addr[7:0]]     <= mem_wdata;
                    wr_flag[mem_addr[7:0]] <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        memRead  = 2'd0;
        memWrite = 2'd0;
        addr     = 16'h0000;
        wdata    = 16'h0000;
    endtask

    task automatic illegal(input string tag, input logic [1:0] rd,
                           input logic [1:0] wr, input logic [15:0] a);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        #1;
        check({tag, "_stall0"}, stall, 1);
        tick();
        idle_in();
        #1;
        check({tag, "_err"}, err, 1);
        check({tag, "_stall1"}, stall, 0);
        check({tag, "_req"}, mem_req, 0);
        tick();
        check({tag, "_err_off"}, err, 0);
        check({tag, "_req2"}, mem_req, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_maddr", mem_addr, 16'h0000);
        check("rst_mwdata", mem_wdata, 8'h00);
        rst_n = 1'b1;
        tick();
        check("idle_stall", stall, 0);

        // mem_ack with no request must be ignored
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        check("ack_idle_done", done, 0);
        check("ack_idle_req", mem_req, 0);

        // word load, zero wait
        dly = 0;
        memRead = 2'd1;
        addr    = 16'h0010;
        #1;
        check("wl_c1_stall", stall, 1);
        check("wl_c1_req", mem_req, 0);
        tick();
        memRead = 2'd2;
        addr    = 16'h0055;
        #1;
        check("wl_c2_req", mem_req, 1);
        check("wl_c2_addr", mem_addr, 16'h0010);
        check("wl_c2_we", mem_we, 0);
        check("wl_c2_stall", stall, 1);
        tick();
        idle_in();
        #1;
        check("wl_c3_addr", mem_addr, 16'h0011);
        check("wl_c3_stall", stall, 1);
        tick();
        check("wl_c4_done", done, 1);
        check("wl_c4_rdata", rdata, 16'hABCD);
        check("wl_c4_stall", stall, 0);
        check("wl_c4_req", mem_req, 0);
        tick();
        check("wl_c5_done", done, 0);

        // byte load with three wait cycles
        dly = 3;
        memRead = 2'd2;
        addr    = 16'h0021;
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            check("bl_req", mem_req, 1);
            check("bl_addr", mem_addr, 16'h0021);
            check("bl_stall", stall, 1);
            check("bl_nodone", done, 0);
            tick();
        end
        check("bl_done", done, 1);
        check("bl_rdata", rdata, 16'h00F0);
        tick();
        check("bl_done_once", done, 0);

        // word store
        dly = 0;
        memWrite = 2'd1;
        wdata    = 16'h1234;
        addr     = 16'h0040;
        tick();
        idle_in();
        #1;
        check("ws_b0_we", mem_we, 1);
        check("ws_b0_addr", mem_addr, 16'h0040);
        check("ws_b0_data", mem_wdata, 8'h12);
        tick();
        check("ws_b1_we", mem_we, 1);
        check("ws_b1_addr", mem_addr, 16'h0041);
        check("ws_b1_data", mem_wdata, 8'h34);
        tick();
        check("ws_done", done, 1);
        check("ws_rdata", rdata, 16'h0000);
        check("ws_mem40", peek(8'h40), 8'h12);
        check("ws_mem41", peek(8'h41), 8'h34);
        tick();

        illegal("il_misalign", 2'd1, 2'd0, 16'h0003);
        illegal("il_both", 2'd1, 2'd1, 16'h0010);
        illegal("il_code3", 2'd3, 2'd0, 16'h0010);
        illegal("il_wcode3", 2'd0, 2'd3, 16'h0010);

        // reset while in BYTE1 of a word load
        memRead = 2'd1;
        addr    = 16'h0010;
        tick();
        idle_in();
        tick();
        check("rs_in_b1", mem_addr, 16'h0011);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rs_req", mem_req, 0);
        check("rs_done", done, 0);
        check("rs_stall", stall, 0);
        check("rs_rdata", rdata, 16'h0000);
        tick();
        check("rs_done2", done, 0);
        check("rs_req2", mem_req, 0);

        // byte store followed at once by a word load
        memWrite = 2'd2;
        wdata    = 16'h77A5;
        addr     = 16'h0050;
        tick();
        memWrite = 2'd0;
        memRead  = 2'd1;
        addr     = 16'h0010;
        wdata    = 16'h0000;
        #1;
        check("bb_st_addr", mem_addr, 16'h0050);
        check("bb_st_we", mem_we, 1);
        check("bb_st_data", mem_wdata, 8'hA5);
        tick();
        check("bb_st_done", done, 1);
        check("bb_st_stall", stall, 0);
        check("bb_st_rdata", rdata, 16'h0000);
        tick();
        check("bb_idle_stall", stall, 1);
        check("bb_idle_req", mem_req, 0);
        check("bb_idle_done", done, 0);
        tick();
        idle_in();
        #1;
        check("bb_ld_addr0", mem_addr, 16'h0010);
        check("bb_ld_we", mem_we, 0);
        tick();
        check("bb_ld_addr1", mem_addr, 16'h0011);
        tick();
        check("bb_ld_done", done, 1);
        check("bb_ld_rdata", rdata, 16'hABCD);
        check("bb_mem50", peek(8'h50), 8'hA5);
        tick();
        check("bb_end_done", done, 0);
        check("bb_end_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
